arm_pipelined_skid_stage: RTL and testbench
===========================================

# arm_pipelined_skid_stage

Parametrised elastic pipeline stage with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It carries `Lanes` data words plus a flag field. It replaces the fixed enable/clear pipeline registers between datapath stages where back-pressure must stop at one stage instead of stalling the whole pipe. It sustains full throughput, and its `o_READY` is registered, so no combinational path runs from the downstream `i_READY` to the upstream stage.

## Interface
- `BusWidth`, default 32: width of one data lane.
- `Lanes`, default 3: number of data lanes packed into `i_Data`/`o_Data`; valid range 1..8.
- `FlagWidth`, default 4: width of the side-band flag field (e.g. NZCV); valid range 1..8.

Reset is `i_NRESET`, asynchronous, active-low; the clock is `i_CLK`.

- `i_CLK`  in  1  clock.
- `i_NRESET`  in  1  asynchronous active-low reset.
- `i_FLUSH`  in  1  synchronous clear; discards all held and offered beats.
- `i_VALID`  in  1  upstream beat valid.
- `o_READY`  out  1  stage can accept a beat this cycle.
- `i_Data`  in  `Lanes*BusWidth`  upstream data; lane k occupies bits `[k*BusWidth +: BusWidth]`.
- `i_Flags`  in  `FlagWidth`  upstream flags.
- `o_VALID`  out  1  downstream beat valid.
- `i_READY`  in  1  downstream accepts the beat.
- `o_Data`  out  `Lanes*BusWidth`  downstream data.
- `o_Flags`  out  `FlagWidth`  downstream flags.
- `o_STALL_CNT`  out  32  stall counter; present only with `ARM_PIPELINED_STAGE_PERF_EN` defined.

## Operation
- Storage: a main register (drives `o_Data`/`o_Flags`) and a skid register, each `Lanes*BusWidth + FlagWidth` bits.
- Handshake events:
  - Input fire: `i_VALID & o_READY`.
  - Output fire: `o_VALID & i_READY`.
- `o_VALID` = (state != EMPTY). `o_READY` = (state != FULL).
- States and transitions:
  - **EMPTY**
    - in fire: main <= in; go to ONE.
    - otherwise: stay.
  - **ONE**
    - in and out fire: main <= in; stay in ONE.
    - in fire only: skid <= in; go to FULL.
    - out fire only: main <= 0; go to EMPTY.
    - neither: hold.
  - **FULL**
    - out fire: main <= skid, skid <= 0; go to ONE.
    - otherwise: hold. No input fire is possible because `o_READY`=0.
- Bubble rule: whenever `o_VALID`=0, `o_Data` and `o_Flags` are all-zero.
- Flush:
  - `i_FLUSH`=1 → next state EMPTY; main and skid cleared to 0.
  - An input beat offered in the same cycle is dropped, even though `o_READY` may read 1.
  - An output fire in the same cycle still counts as delivered downstream.
- Ordering: beats leave in acceptance order. No loss and no duplication outside flush.
- Priority: reset > flush > handshake.

## Timing
- Reset values: `o_VALID`=0, `o_READY`=1, `o_Data`=0, `o_Flags`=0, `o_STALL_CNT`=0, state EMPTY.
- Latency: a beat accepted at edge N is visible on `o_Data` with `o_VALID`=1 after edge N.
- Throughput: one beat per cycle while `i_READY`=1.
- `o_READY` drops the cycle after the second un-drained beat is accepted and rises the cycle after the output fire out of FULL.
- All outputs are driven directly from flops; there is no combinational input-to-output path.
- Reset asserted mid-transfer: every held beat is lost, and outputs go to reset values immediately (asynchronously).
- Flush release: `o_READY`=1 and a new beat can be accepted on the first cycle after the flush edge.

## Configuration
- Macro: `ARM_PIPELINED_STAGE_PERF_EN`.
- With the macro defined:
  - The `o_STALL_CNT` port and counter exist.
  - The counter increments on every cycle with `o_VALID & ~i_READY`.
  - It saturates at `32'hFFFFFFFF`.
  - It is cleared only by `i_NRESET`, not by `i_FLUSH`.
- Without the macro: the port and counter are absent and the rest of the behaviour is identical.

## Test plan
- Reset: drive `i_NRESET`=0 with random inputs → `o_VALID`=0, `o_READY`=1, `o_Data`=0, `o_Flags`=0; the first beat after release is accepted.
- Streaming: `i_READY`=1; send lane-0 values 0x11, 0x22, 0x33 back-to-back → `o_Data` lane 0 shows 0x11, 0x22, 0x33 on consecutive cycles, one cycle delayed; `o_READY` stays 1 throughout.
- Back-pressure: `i_READY`=0; send A=0xA, then B=0xB → `o_Data`=0xA and `o_READY`=0 after the second accept. Raise `i_READY` → outputs 0xA then 0xB, then `o_VALID`=0 with `o_Data`=0.
- Flush in FULL: pulse `i_FLUSH` with `i_VALID`=1 and data 0xC → next cycle `o_VALID`=0, `o_Data`=0, `o_READY`=1; 0xC never appears at the output.
- Async reset mid-stream: assert `i_NRESET` low between edges while in ONE → outputs reach reset values before the next edge; no stale beat appears after release.
- Perf (macro defined): hold a valid beat with `i_READY`=0 for 5 cycles → `o_STALL_CNT`=5. Then pulse `i_FLUSH` → `o_STALL_CNT` remains 5.

Source files
------------

// File: rtl/arm_pipelined_skid_stage.sv
// Elastic pipeline stage: valid/ready handshake, two-entry skid buffer, synchronous flush.
// Optional stall counter on o_STALL_CNT when ARM_PIPELINED_STAGE_PERF_EN is defined.
module arm_pipelined_skid_stage #(
    parameter int BusWidth  = 32,
    parameter int Lanes     = 3,
    parameter int FlagWidth = 4
) (
    input  logic                      i_CLK,
    input  logic                      i_NRESET,
    input  logic                      i_FLUSH,
    input  logic                      i_VALID,
    output logic                      o_READY,
    input  logic [Lanes*BusWidth-1:0] i_Data,
    input  logic [FlagWidth-1:0]      i_Flags,
    output logic                      o_VALID,
    input  logic                      i_READY,
    output logic [Lanes*BusWidth-1:0] o_Data,
    output logic [FlagWidth-1:0]      o_Flags
`ifdef ARM_PIPELINED_STAGE_PERF_EN
    ,
    output logic [31:0]               o_STALL_CNT
`endif
);

    localparam int Width = Lanes*BusWidth + FlagWidth;

    // Encoding chosen so o_VALID/o_READY are single state bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state, state_next;
    logic [Width-1:0] main_q, main_next;
    logic [Width-1:0] skid_q, skid_next;
    logic             in_fire, out_fire;

    assign o_VALID  = (state != EMPTY);
    assign o_READY  = (state != FULL);
    assign in_fire  = i_VALID & o_READY;
    assign out_fire = o_VALID & i_READY;

    assign o_Data  = main_q[Width-1:FlagWidth];
    assign o_Flags = main_q[FlagWidth-1:0];

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    // Main is zeroed whenever the stage drains, which gives all-zero bubbles.
    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        if (i_FLUSH) begin
            state_next = EMPTY;
            main_next  = '0;
            skid_next  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_next  = {i_Data, i_Flags};
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = {i_Data, i_Flags};
                    end else if (in_fire) begin
                        skid_next  = {i_Data, i_Flags};
                        state_next = FULL;
                    end else if (out_fire) begin
                        main_next  = '0;
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_next  = skid_q;
                        skid_next  = '0;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = '0;
                    skid_next  = '0;
                end
            endcase
        end
    end

`ifdef ARM_PIPELINED_STAGE_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge i_CLK or negedge i_NRESET) begin
        if (!i_NRESET) begin
            stall_cnt <= '0;
        end else if (o_VALID && !i_READY && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_STALL_CNT = stall_cnt;
`endif

endmodule

// File: tb/tb_arm_pipelined_skid_stage.sv
// Bench for arm_pipelined_skid_stage: queue model checked every cycle plus directed literal checks.
module tb_arm_pipelined_skid_stage;

    localparam int BusWidth  = 32;
    localparam int Lanes     = 3;
    localparam int FlagWidth = 4;
    localparam int DW        = Lanes*BusWidth;
    localparam int W         = DW + FlagWidth;

    logic                 clk = 1'b0;
    logic                 nrst = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DW-1:0]        in_data = '0;
    logic [FlagWidth-1:0] in_flags = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [DW-1:0]        out_data;
    logic [FlagWidth-1:0] out_flags;
    logic [31:0]          stall_cnt;

    int errors = 0;
    int checks = 0;

    arm_pipelined_skid_stage #(
        .BusWidth (BusWidth),
        .Lanes    (Lanes),
        .FlagWidth(FlagWidth)
    ) dut (
        .i_CLK      (clk),
        .i_NRESET   (nrst),
        .i_FLUSH    (flush),
        .i_VALID    (in_valid),
        .o_READY    (in_ready),
        .i_Data     (in_data),
        .i_Flags    (in_flags),
        .o_VALID    (out_valid),
        .i_READY    (out_ready),
        .o_Data     (out_data),
        .o_Flags    (out_flags)
`ifdef ARM_PIPELINED_STAGE_PERF_EN
        ,
        .o_STALL_CNT(stall_cnt)
`endif
    );

`ifndef ARM_PIPELINED_STAGE_PERF_EN
    assign stall_cnt = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of accepted beats, at most two deep.
    logic [W-1:0] mq[$];
    logic [31:0]  m_stall = '0;

    initial begin
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                mq.delete();
                m_stall = '0;
            end else begin
                automatic bit inf  = in_valid && (mq.size() < 2);
                automatic bit outf = (mq.size() > 0) && out_ready;
                if ((mq.size() > 0) && !out_ready && (m_stall != 32'hFFFF_FFFF))
                    m_stall = m_stall + 1;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (outf) void'(mq.pop_front());
                    if (inf) mq.push_back({in_data, in_flags});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_valid", 128'(out_valid), 128'(mq.size() > 0));
            chk("cyc_ready", 128'(in_ready), 128'(mq.size() < 2));
            chk("cyc_data", 128'(out_data), (mq.size() > 0) ? 128'(mq[0][W-1:FlagWidth]) : 128'd0);
            chk("cyc_flags", 128'(out_flags), (mq.size() > 0) ? 128'(mq[0][FlagWidth-1:0]) : 128'd0);
`ifdef ARM_PIPELINED_STAGE_PERF_EN
            chk("cyc_stall", 128'(stall_cnt), 128'(m_stall));
`endif
        end
    end

    function automatic logic [DW-1:0] mk(input logic [31:0] v);
        logic [DW-1:0] d;
        for (int k = 0; k < Lanes; k++) d[k*BusWidth +: BusWidth] = v + 32'(k) * 32'h100;
        return d;
    endfunction

    // Apply inputs for one edge, then return 1 time unit after that edge.
    task automatic drive(input logic v, input logic [31:0] val, input logic r, input logic fl);
        in_valid  = v;
        in_data   = mk(val);
        in_flags  = val[FlagWidth-1:0];
        out_ready = r;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane0();
        return out_data[31:0];
    endfunction

    initial begin
        // Reset with random inputs
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom, $urandom};
        in_flags  = 4'($urandom);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(out_valid), 128'd0);
        chk("rst_ready", 128'(in_ready), 128'd1);
        chk("rst_data", 128'(out_data), 128'd0);
        chk("rst_flags", 128'(out_flags), 128'd0);
        chk("rst_stall", 128'(stall_cnt), 128'd0);
        nrst = 1'b1;

        // Streaming
        drive(1, 32'h11, 1, 0);
        chk("stream_11", 128'(lane0()), 128'h11);
        chk("stream_11_lane2", 128'(out_data[95:64]), 128'h211);
        chk("stream_11_flags", 128'(out_flags), 128'h1);
        drive(1, 32'h22, 1, 0);
        chk("stream_22", 128'(lane0()), 128'h22);
        chk("stream_rdy", 128'(in_ready), 128'd1);
        drive(1, 32'h33, 1, 0);
        chk("stream_33", 128'(lane0()), 128'h33);
        chk("stream_rdy2", 128'(in_ready), 128'd1);
        drive(0, 32'h0, 1, 0);
        chk("stream_drain_v", 128'(out_valid), 128'd0);
        chk("stream_drain_d", 128'(out_data), 128'd0);

        // Back-pressure
        drive(1, 32'hA, 0, 0);
        chk("bp_a", 128'(lane0()), 128'hA);
        chk("bp_rdy1", 128'(in_ready), 128'd1);
        drive(1, 32'hB, 0, 0);
        chk("bp_hold_a", 128'(lane0()), 128'hA);
        chk("bp_rdy0", 128'(in_ready), 128'd0);
        drive(1, 32'hBAD, 0, 0);
        chk("bp_still_a", 128'(lane0()), 128'hA);
        drive(0, 32'h0, 1, 0);
        chk("bp_b", 128'(lane0()), 128'hB);
        chk("bp_rdy_back", 128'(in_ready), 128'd1);
        drive(0, 32'h0, 1, 0);
        chk("bp_empty_v", 128'(out_valid), 128'd0);
        chk("bp_empty_d", 128'(out_data), 128'd0);

        // Flush in FULL with an offered beat
        drive(1, 32'hD, 0, 0);
        drive(1, 32'hE, 0, 0);
        chk("fl_full", 128'(in_ready), 128'd0);
        drive(1, 32'hC, 0, 1);
        chk("fl_v", 128'(out_valid), 128'd0);
        chk("fl_d", 128'(out_data), 128'd0);
        chk("fl_rdy", 128'(in_ready), 128'd1);
        drive(1, 32'h5, 1, 0);
        chk("fl_release", 128'(lane0()), 128'h5);
        drive(0, 32'h0, 1, 0);
        chk("fl_no_c", 128'(out_valid), 128'd0);

        // Async reset while in ONE
        drive(1, 32'h6, 0, 0);
        chk("ar_one", 128'(lane0()), 128'h6);
        in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("ar_v", 128'(out_valid), 128'd0);
        chk("ar_d", 128'(out_data), 128'd0);
        chk("ar_rdy", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1 nrst = 1'b1;
        drive(0, 32'h0, 1, 0);
        chk("ar_no_stale", 128'(out_valid), 128'd0);
        drive(1, 32'h9, 1, 0);
        chk("ar_first", 128'(lane0()), 128'h9);
        drive(0, 32'h0, 1, 0);

`ifdef ARM_PIPELINED_STAGE_PERF_EN
        // Stall counter from a clean reset
        nrst = 1'b0;
        #1 nrst = 1'b1;
        drive(1, 32'h7, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 32'h0, 0, 0);
        chk("perf_5", 128'(stall_cnt), 128'd5);
        drive(0, 32'h0, 1, 1);
        chk("perf_flush", 128'(stall_cnt), 128'd5);
        drive(0, 32'h0, 1, 0);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
